// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache between Fetch and the MemController fetch port.
// Hits return data combinationally; a miss refills one word per cycle, stalling 4 cycles.
// ic_if_stall holds Fetch during refill; MemController must answer in the same cycle.
module icache_direct #(
   parameter int INDEX_BITS  = 4,
   parameter int OFFSET_BITS = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        if_ic_en,
   input  logic [31:0] if_ic_addr,
   output logic [31:0] ic_if_data,
   output logic        ic_if_stall,
   output logic        ic_mc_en,
   output logic [31:0] ic_mc_addr,
   input  logic [31:0] mc_ic_data,
   input  logic        inv_all,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   localparam int LINES    = 1 << INDEX_BITS;
   localparam int WORDS    = 1 << OFFSET_BITS;
   localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS - 2;

   typedef enum logic {IDLE, REFILL} state_t;

   state_t                  state_q, state_d;
   logic [OFFSET_BITS-1:0]  cnt_q, cnt_d;
   logic [LINES-1:0]        valid_q, valid_d;
   logic [TAG_BITS-1:0]     tag_q [LINES];
   logic [TAG_BITS-1:0]     tag_d [LINES];
   logic [31:0]             data_q [LINES][WORDS];
   logic [31:0]             data_d [LINES][WORDS];
   logic [TAG_BITS-1:0]     rtag_q, rtag_d;
   logic [INDEX_BITS-1:0]   ridx_q, ridx_d;
   logic [31:0]             hit_q, hit_d;
   logic [31:0]             miss_q, miss_d;

   logic [TAG_BITS-1:0]     tag_w;
   logic [INDEX_BITS-1:0]   idx_w;
   logic [OFFSET_BITS-1:0]  off_w;
   logic                    hit_w;
   logic                    unused_addr_bits;

   assign tag_w = if_ic_addr[31 -: TAG_BITS];
   assign idx_w = if_ic_addr[OFFSET_BITS+2 +: INDEX_BITS];
   assign off_w = if_ic_addr[2 +: OFFSET_BITS];
   assign hit_w = valid_q[idx_w] && (tag_q[idx_w] == tag_w);
   assign unused_addr_bits = ^if_ic_addr[1:0];

   assign hit_count  = hit_q;
   assign miss_count = miss_q;

   // Lookup, refill sequencing and next-state computation; reset forces outputs quiet.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      valid_d     = valid_q;
      tag_d       = tag_q;
      data_d      = data_q;
      rtag_d      = rtag_q;
      ridx_d      = ridx_q;
      hit_d       = hit_q;
      miss_d      = miss_q;
      ic_if_data  = 32'd0;
      ic_if_stall = 1'b0;
      ic_mc_en    = 1'b0;
      ic_mc_addr  = 32'd0;

      if (!reset) begin
         case (state_q)
            IDLE: begin
               if (if_ic_en) begin
                  if (hit_w) begin
                     ic_if_data = data_q[idx_w][off_w];
                     hit_d      = hit_q + 32'd1;
                  end else begin
                     ic_if_stall = 1'b1;
                     ic_mc_en    = 1'b1;
                     ic_mc_addr  = {tag_w, idx_w, {OFFSET_BITS{1'b0}}, 2'b00};
                     // The old line is being overwritten, so it must not hit again.
                     valid_d[idx_w]   = 1'b0;
                     data_d[idx_w][0] = mc_ic_data;
                     rtag_d           = tag_w;
                     ridx_d           = idx_w;
                     cnt_d            = 1;
                     state_d          = REFILL;
                     miss_d           = miss_q + 32'd1;
                  end
               end
            end
            REFILL: begin
               ic_if_stall = 1'b1;
               ic_mc_en    = 1'b1;
               ic_mc_addr  = {rtag_q, ridx_q, cnt_q, 2'b00};
               data_d[ridx_q][cnt_q] = mc_ic_data;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == OFFSET_BITS'(WORDS - 1)) begin
                  tag_d[ridx_q]   = rtag_q;
                  valid_d[ridx_q] = 1'b1;
                  cnt_d           = '0;
                  state_d         = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
         // Invalidate wins over the final valid set of a refill.
         if (inv_all) valid_d = '0;
      end
   end

   // Control state, valid bits and counters with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         valid_q <= '0;
         hit_q   <= 32'd0;
         miss_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
      end
   end

   // Tag/data storage and latched refill target; contents are meaningless until valid.
   always_ff @(posedge clock) begin
      tag_q  <= tag_d;
      data_q <= data_d;
      rtag_q <= rtag_d;
      ridx_q <= ridx_d;
   end

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios plus random traffic
// checked every cycle against a line-level model of the cache.
module tb_icache_direct;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [31:0] addr;
   logic        inv;
   logic [31:0] ic_if_data;
   logic        ic_if_stall;
   logic        ic_mc_en;
   logic [31:0] ic_mc_addr;
   logic [31:0] mc_ic_data;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   logic [31:0] mem [1024];
   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   assign mc_ic_data = mem[ic_mc_addr[11:2]];

   icache_direct dut (
      .clock      (clk),
      .reset      (rst),
      .if_ic_en   (en),
      .if_ic_addr (addr),
      .ic_if_data (ic_if_data),
      .ic_if_stall(ic_if_stall),
      .ic_mc_en   (ic_mc_en),
      .ic_mc_addr (ic_mc_addr),
      .mc_ic_data (mc_ic_data),
      .inv_all    (inv),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   bit          m_valid [16];
   logic [31:0] m_tag   [16];
   int          m_busy;          // stall cycles still to come after the current one
   logic [31:0] m_base;          // byte address of the line being refilled
   logic [31:0] m_hits, m_miss;

   // Compare DUT outputs to the model mid-cycle, then advance the model across the edge.
   always @(negedge clk) begin
      if (chk_en) begin
         int idx;
         logic [31:0] tg;
         idx = int'((addr >> 4) % 16);
         tg  = addr >> 8;
         check("hit_count", hit_count, m_hits);
         check("miss_count", miss_count, m_miss);
         if (rst) begin
            check("rst_stall", 32'(ic_if_stall), 0);
            check("rst_mc_en", 32'(ic_mc_en), 0);
            check("rst_mc_addr", ic_mc_addr, 0);
            check("rst_data", ic_if_data, 0);
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_busy = 0;
            m_hits = 0;
            m_miss = 0;
         end else if (m_busy > 0) begin
            check("refill_stall", 32'(ic_if_stall), 1);
            check("refill_mc_en", 32'(ic_mc_en), 1);
            check("refill_mc_addr", ic_mc_addr, m_base + 32'(4 * (4 - m_busy)));
            m_busy--;
            if (m_busy == 0) begin
               m_valid[(m_base >> 4) % 16] = 1'b1;
               m_tag[(m_base >> 4) % 16]   = m_base >> 8;
            end
         end else if (en) begin
            if (m_valid[idx] && m_tag[idx] == tg) begin
               check("hit_stall", 32'(ic_if_stall), 0);
               check("hit_mc_en", 32'(ic_mc_en), 0);
               check("hit_data", ic_if_data, mem[addr[11:2]]);
               m_hits++;
            end else begin
               check("miss_stall", 32'(ic_if_stall), 1);
               check("miss_mc_en", 32'(ic_mc_en), 1);
               m_base = {addr[31:4], 4'h0};
               check("miss_mc_addr", ic_mc_addr, m_base);
               m_valid[idx] = 1'b0;
               m_busy = 3;
               m_miss++;
            end
         end else begin
            check("idle_stall", 32'(ic_if_stall), 0);
            check("idle_mc_en", 32'(ic_mc_en), 0);
            check("idle_data", ic_if_data, 0);
         end
         if (!rst && inv) foreach (m_valid[i]) m_valid[i] = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run a refill's remaining three stall cycles, checking the addresses literally.
   task automatic finish_refill(input logic [31:0] base);
      for (int k = 1; k < 4; k++) begin
         tick();
         #2 check("lit_refill_addr", ic_mc_addr, base + 32'(4 * k));
      end
      tick();
   endtask

   initial begin
      foreach (mem[i]) mem[i] = $urandom;
      mem[0] = 32'h20080005;
      mem[1] = 32'h20090003;
      mem[2] = 32'h01095020;
      mem[3] = 32'h00000000;
      rst = 1'b1; en = 1'b0; addr = 32'd0; inv = 1'b0;
      tick(); tick();
      chk_en = 1'b1;
      tick();
      rst = 1'b0;

      // Cold miss on 0x00: four stall cycles, then hit.
      en = 1'b1; addr = 32'h0;
      for (int k = 0; k < 4; k++) begin
         #2 check("t1_stall", 32'(ic_if_stall), 1);
         check("t1_mc_addr", ic_mc_addr, 32'(4 * k));
         tick();
      end
      #2 check("t1_data", ic_if_data, 32'h20080005);
      check("t1_nostall", 32'(ic_if_stall), 0);
      tick();
      check("t1_miss", miss_count, 1);
      check("t1_hit", hit_count, 1);

      // Sequential hits in the same line.
      addr = 32'h4; #2 check("t2_d4", ic_if_data, 32'h20090003);
      tick();
      addr = 32'h8; #2 check("t2_d8", ic_if_data, 32'h01095020);
      check("t2_mc_en", 32'(ic_mc_en), 0);
      tick();
      addr = 32'hC; #2 check("t2_dC", ic_if_data, 32'h00000000);
      tick();
      check("t2_hit", hit_count, 4);

      // Conflict on index 0.
      addr = 32'h100; #2 check("t3_addr", ic_mc_addr, 32'h100);
      finish_refill(32'h100);
      tick();
      addr = 32'h0; #2 check("t3_remiss", 32'(ic_if_stall), 1);
      tick();
      check("t3_miss", miss_count, 3);
      finish_refill_rest: for (int k = 1; k < 4; k++) tick();
      tick();

      // Idle invalidate, then address change mid-refill.
      en = 1'b0; inv = 1'b1; tick(); inv = 1'b0;
      en = 1'b1; addr = 32'h0; #2 check("t4_inv_miss", 32'(ic_if_stall), 1);
      tick();
      addr = 32'h40; #2 check("t4_held_addr", ic_mc_addr, 32'h4);
      tick();
      #2 check("t4_held_addr2", ic_mc_addr, 32'h8);
      tick(); tick();
      #2 check("t4_new_miss", ic_mc_addr, 32'h40);
      finish_refill(32'h40);
      tick();

      // Invalidate in the last refill cycle.
      addr = 32'h200; tick(); tick(); tick();
      inv = 1'b1; #2 check("t5_last_addr", ic_mc_addr, 32'h20C);
      tick(); inv = 1'b0;
      #2 check("t5_remiss", 32'(ic_if_stall), 1);
      check("t5_remiss_addr", ic_mc_addr, 32'h200);
      finish_refill(32'h200);
      #2 check("t5_hit", ic_if_data, mem[32'h200 >> 2]);
      tick();

      // Reset during the third refill cycle.
      addr = 32'h300; tick(); tick();
      rst = 1'b1; tick();
      #2 check("t6_mc_en", 32'(ic_mc_en), 0);
      check("t6_stall", 32'(ic_if_stall), 0);
      check("t6_hits", hit_count, 0);
      check("t6_miss", miss_count, 0);
      tick();
      rst = 1'b0;
      #2 check("t6_restart", ic_mc_addr, 32'h300);
      finish_refill(32'h300);

      // Random traffic against the model.
      for (int n = 0; n < 4000; n++) begin
         en   = ($urandom_range(0, 3) != 0);
         addr = {20'd0, 4'($urandom_range(0, 2)), 4'($urandom), 4'($urandom)};
         inv  = ($urandom_range(0, 49) == 0);
         rst  = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0; en = 1'b0; inv = 1'b0;
      tick(); tick();
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
Direct-mapped, read-only instruction cache between the Fetch stage and MemController's fetch port.
- Fetch's if_mc_en/if_mc_addr/mc_if_data connections move to this block.
- The block drives MemController's fetch port on refills.
- Hits return the instruction in the same cycle.
- Misses stall Fetch while a whole line is refilled one word per cycle through the single-cycle MemController/Ram path.

Parameters:
INDEX_BITS, 4, log2 of line count (16 lines).
OFFSET_BITS, 2, log2 of words per line (4 words, 16 bytes).

Ports:
clock  input  1  system clock, all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
if_ic_en  input  1  Fetch requests an instruction this cycle.
if_ic_addr  input  32  byte address of the instruction; bits [1:0] are ignored.
ic_if_data  output  32  instruction returned to Fetch; valid when if_ic_en=1 and ic_if_stall=0.
ic_if_stall  output  1  Fetch must hold PC and if_ic_addr.
ic_mc_en  output  1  fetch-port enable toward MemController.
ic_mc_addr  output  32  word-aligned refill address toward MemController.
mc_ic_data  input  32  word returned combinationally by MemController in the same cycle.
inv_all  input  1  invalidate every line.
hit_count  output  32  count of completed hits.
miss_count  output  32  count of misses started.

Behaviour:
- Address split:
  - offset = addr[OFFSET_BITS+1:2]
  - index = addr[INDEX_BITS+OFFSET_BITS+1:OFFSET_BITS+2]
  - tag = the remaining upper bits (24 bits at defaults).
- Storage per line: valid bit, tag, 4 data words. Register arrays are acceptable.
- Reset (synchronous): all valid bits=0, FSM=IDLE, refill counter=0, hit_count=0, miss_count=0.
- Outputs while reset is high: ic_mc_en=0, ic_mc_addr=0, ic_if_stall=0, ic_if_data=0.
- FSM states: IDLE, REFILL.
- IDLE, if_ic_en=0:
  - ic_if_stall=0, ic_if_data=0, ic_mc_en=0.
  - No state change.
- IDLE, hit (valid[index] and tag match):
  - ic_if_data=line word[offset] combinationally; ic_if_stall=0.
  - hit_count increments at the edge.
- IDLE, miss:
  - ic_if_stall=1, ic_mc_en=1, ic_mc_addr = {tag, index, 2'b00 offset, 2'b00}, i.e. word 0 of the line.
  - At the edge: store mc_ic_data into word 0; latch refill tag and index; counter=1; go to REFILL; miss_count increments.
- REFILL:
  - ic_if_stall=1, ic_mc_en=1, ic_mc_addr = latched line base + 4*counter.
  - Each edge stores mc_ic_data into word[counter], then increments counter.
  - When counter=3 at the edge: write the latched tag, set valid (unless invalidated, see below), counter=0, go to IDLE.
- Miss penalty:
  - ic_if_stall is high exactly 4 cycles (words 0..3).
  - The 5th cycle re-looks-up the held address and hits.
- if_ic_addr/if_ic_en changes during REFILL are ignored; the refill always completes for the latched line. The next IDLE cycle does a fresh lookup.
- Data returned on a hit is always the stored copy. Words are never forwarded mid-refill.
- inv_all:
  - At the edge, clears all valid bits and has priority over the refill's final valid set. The refilled line ends invalid.
  - Does not abort or shorten a refill; counters are unaffected.
- Counters wrap modulo 2^32.
- Single-cycle MemController latency is a hard requirement: mc_ic_data must be valid in the same cycle as ic_mc_en/ic_mc_addr.
- The block is read-only. Data-side stores are not snooped; software must pulse inv_all after self-modifying code.

Test Plan:
- Reset, then if_ic_en=1, addr 0x00; Ram words 0x00..0x0C = 0x20080005, 0x20090003, 0x01095020, 0x00000000:
  - stall=1 for 4 cycles; ic_mc_addr = 0x00, 0x04, 0x08, 0x0C.
  - Cycle 5: ic_if_data=0x20080005, stall=0; miss_count=1, hit_count=1.
- Sequential addrs 0x04, 0x08, 0x0C after that refill:
  - Hits with zero stall, returning 0x20090003, 0x01095020, 0x00000000.
  - hit_count=4, ic_mc_en stays 0.
- Conflict: fetch 0x100 (same index 0, tag 0x000001) after the line at 0x00 is filled:
  - 4-cycle refill from 0x100..0x10C, then fetch 0x00 misses again.
  - miss_count=3.
- Change if_ic_addr to 0x40 during the 2nd refill cycle of line 0x00:
  - Refill still reads 0x00..0x0C.
  - Next cycle 0x40 misses and starts a refill at 0x40.
- Pulse inv_all in the last refill cycle:
  - Line stays invalid; the held address misses again (stall 4 more cycles).
  - A separate pulse while idle makes previously hit addresses miss.
- Assert reset in the 3rd refill cycle:
  - Next cycle ic_mc_en=0 and stall=0 while reset is held, counters=0.
  - After release, the same address refills from word 0.
